// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer
//
// Drives the four input vectors 00, 01, 10, 11 into an external 2-input gate,
// samples the gate output once per vector and compares it with the truth table
// selected by gate_sel. Vectors advance on a dwell timer (auto mode) or on
// each rising edge of step_btn (step mode). Per-vector mismatches collect in
// fail_vec, and pass summarises the run once it is done.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   start      one-cycle pulse, starts a run from idle or done
//   step_mode  0 = auto (dwell timer), 1 = manual (step_btn)
//   step_btn   debounced, synchronised button level
//   gate_sel   expected function: AND, OR, XOR, NAND, NOR, XNOR, NOT a, BUF a
//   dut_y      output of the gate under test
//   dut_a      gate input a (registered)
//   dut_b      gate input b (registered)
//   vec_idx    index {a,b} of the vector currently applied
//   busy       run in progress
//   done       run finished, held until the next start
//   pass       run finished with no mismatches
//   fail_vec   bit i set when vector i mismatched
module gate_test_sequencer #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       step_mode,
  input  logic       step_btn,
  input  logic [2:0] gate_sel,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      gate_q, gate_d;
  logic            step_q;
  logic            mode_q;
  logic [1:0]      vec_q, vec_d;
  logic [3:0]      fail_q, fail_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            a_q, b_q;

  logic exp_y;
  logic step_rise;
  logic mode_chg;
  logic sample;

  assign step_rise = step_btn & ~step_q;
  assign mode_chg  = step_mode ^ mode_q;

  // Expected gate output for the vector currently on the pins.
  always_comb begin
    exp_y = 1'b0;
    case (gate_q)
      3'd0:    exp_y = a_q & b_q;
      3'd1:    exp_y = a_q | b_q;
      3'd2:    exp_y = a_q ^ b_q;
      3'd3:    exp_y = ~(a_q & b_q);
      3'd4:    exp_y = ~(a_q | b_q);
      3'd5:    exp_y = ~(a_q ^ b_q);
      3'd6:    exp_y = ~a_q;
      default: exp_y = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gate_d  = gate_q;
    vec_d   = vec_q;
    fail_d  = fail_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    sample  = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          gate_d  = gate_sel;
          vec_d   = 2'd0;
          cnt_d   = '0;
          fail_d  = 4'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        if (step_mode) begin
          cnt_d  = '0;
          sample = step_rise;
        end else if (mode_chg) begin
          // Returning to auto mode restarts the dwell for the current vector.
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          cnt_d  = '0;
          sample = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end

        if (sample) begin
          if (dut_y != exp_y) begin
            fail_d = fail_q | (4'd1 << vec_q);
          end
          if (vec_q == 2'd3) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = ~|fail_d;
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gate_q  <= 3'd0;
      step_q  <= 1'b0;
      mode_q  <= 1'b0;
      vec_q   <= 2'd0;
      fail_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      step_q  <= step_btn;
      mode_q  <= step_mode;
      vec_q   <= vec_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      // Pins mirror the next vector index so they change on the same edge.
      a_q     <= vec_d[1];
      b_q     <= vec_d[0];
    end
  end

  assign dut_a    = a_q;
  assign dut_b    = b_q;
  assign vec_idx  = vec_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_vec = fail_q;

endmodule
